// File: rtl/loopback_pkg.sv
// -----------------------------------------------------------------------------
// loopback_pkg
// Shared definitions for the HPIO TX->RX loopback link controller.
//   - link_state_t : bring-up / link FSM states (encoding is visible on the
//                    debug 'state' port, so the values are fixed)
//   - MAX_DW       : widest data word the rotate helper supports
//   - ERR_CNT_MAX  : saturation value of the link error counter
//   - rotl()       : rotate-left of the low 'width' bits of a word
// -----------------------------------------------------------------------------
package loopback_pkg;

    localparam int MAX_DW = 64;

    localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_WAIT_PLL = 3'd0,
        ST_WAIT_SEQ = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_ALIGN    = 3'd4,
        ST_LOCKED   = 3'd5
    } link_state_t;

    // Rotate the low 'width' bits of 'word' left by 'amount' (amount < width).
    // Built from two shifts and a mask so that it stays a plain barrel
    // shifter in hardware; bits above 'width' come back as zero.
    function automatic logic [MAX_DW-1:0] rotl(
        input logic [MAX_DW-1:0] word,
        input int unsigned       width,
        input int unsigned       amount
    );
        logic [MAX_DW-1:0] mask;
        logic [MAX_DW-1:0] masked;
        mask   = (width >= MAX_DW) ? '1 : ((MAX_DW'(1) << width) - MAX_DW'(1));
        masked = word & mask;
        if (amount == 0) begin
            return masked;
        end
        return ((masked << amount) | (masked >> (width - amount))) & mask;
    endfunction

endpackage

// File: rtl/word_aligner.sv
// -----------------------------------------------------------------------------
// word_aligner
// Rotates each valid RX word by the current slip amount, registers it, and
// compares it against the previously accepted word to flag counter
// continuity.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   rx_valid      : qualifies rx_data
//   rx_data       : raw word from the RX deserialiser
//   slip          : rotate-left amount applied to rx_data
//   flush         : forget the reference word (next usable word only reloads it)
//   aligned_data  : registered, rotated word
//   good / bad    : combinational verdict on the word currently in aligned_data
// -----------------------------------------------------------------------------
module word_aligner
    import loopback_pkg::*;
#(
    parameter int DW = 8,
    parameter int SW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_valid,
    input  logic [DW-1:0] rx_data,
    input  logic [SW-1:0] slip,
    input  logic          flush,
    output logic [DW-1:0] aligned_data,
    output logic          good,
    output logic          bad
);

    logic          aligned_vld;
    logic [SW-1:0] aligned_slip;
    logic [DW-1:0] prev;
    logic          prev_ok;
    logic          usable;
    logic          match;

    // Alignment stage: rotate each valid word and remember which slip value
    // it was rotated with. The slip tag lets the compare stage drop the one
    // word still in flight when the slip amount changes underneath it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aligned_vld  <= 1'b0;
            aligned_slip <= '0;
            aligned_data <= '0;
        end else begin
            aligned_vld <= rx_valid;
            if (rx_valid) begin
                aligned_data <= DW'(rotl(MAX_DW'(rx_data), DW, 32'(slip)));
                aligned_slip <= slip;
            end
        end
    end

    // Compare verdict: a word is only judged when it was rotated with the
    // slip value in force now and there is a valid reference to compare to.
    always_comb begin
        usable = 1'b0;
        match  = 1'b0;
        good   = 1'b0;
        bad    = 1'b0;
        usable = aligned_vld && (aligned_slip == slip);
        match  = (aligned_data == prev + DW'(1));
        good   = usable && prev_ok && match;
        bad    = usable && prev_ok && !match;
    end

    // Reference word: every usable word becomes the new reference, bad ones
    // included, so a single skipped counter value costs exactly one error.
    // A flush drops the reference; the following usable word just reloads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev    <= '0;
            prev_ok <= 1'b0;
        end else if (flush) begin
            prev_ok <= 1'b0;
        end else if (usable) begin
            prev    <= aligned_data;
            prev_ok <= 1'b1;
        end
    end

endmodule

// File: rtl/loopback_link_ctrl.sv
// -----------------------------------------------------------------------------
// loopback_link_ctrl
// Bring-up sequencer and link checker for the HPIO TX->RX loopback path.
// Waits for PLL lock, reset-sequence completion and delay/VTC ready, holds
// the counter source in reset for a settle period, then searches for the bit
// rotation that turns the RX stream back into an incrementing counter and
// monitors the link once it is found.
//
// Ports:
//   clk, rst_n                       : clk_200m, asynchronous active-low reset
//   tx_pll_locked, rx_pll_locked     : HPIO PLL lock flags
//   tx_rst_seq_done, rx_rst_seq_done : HPIO reset sequence done flags
//   tx_rdy, rx_rdy                   : ANDed vtc/dly ready flags per side
//   rx_valid, rx_data                : RX fabric word and its qualifier
//   source_rst                       : active-high reset to counter_datagen
//   en_vtc                           : drives every en_vtc_bsc* input
//   slip                             : rotate-left amount applied to rx_data
//   aligned_data                     : rotated rx_data, one cycle later
//   link_up                          : high only while LOCKED
//   err_cnt                          : bad words seen while LOCKED, saturating
//   timeout                          : sticky "no lock within budget" flag
//   state                            : FSM encoding for debug
// -----------------------------------------------------------------------------
module loopback_link_ctrl
    import loopback_pkg::*;
#(
    parameter int DW             = 8,
    parameter int SETTLE_CYCLES  = 64,
    parameter int LOCK_WORDS     = 16,
    parameter int ERR_LIMIT      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_pll_locked,
    input  logic                  rx_pll_locked,
    input  logic                  tx_rst_seq_done,
    input  logic                  rx_rst_seq_done,
    input  logic                  tx_rdy,
    input  logic                  rx_rdy,
    input  logic                  rx_valid,
    input  logic [DW-1:0]         rx_data,
    output logic                  source_rst,
    output logic                  en_vtc,
    output logic [$clog2(DW)-1:0] slip,
    output logic [DW-1:0]         aligned_data,
    output logic                  link_up,
    output logic [15:0]           err_cnt,
    output logic                  timeout,
    output logic [2:0]            state
);

    localparam int SW     = $clog2(DW);
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int GOOD_W = $clog2(LOCK_WORDS + 1);
    localparam int BAD_W  = $clog2(ERR_LIMIT + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SW-1:0]     SLIP_LAST  = SW'(DW - 1);
    localparam logic [SET_W-1:0]  SETTLE_END = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [GOOD_W-1:0] GOOD_END   = GOOD_W'(LOCK_WORDS - 1);
    localparam logic [BAD_W-1:0]  BAD_END    = BAD_W'(ERR_LIMIT - 1);
    localparam logic [TMO_W-1:0]  TMO_END    = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX    = TMO_W'(TIMEOUT_CYCLES);

    link_state_t       state_q;
    link_state_t       state_d;
    logic              pll_ok;
    logic              pll_loss;
    logic              flush;
    logic              good;
    logic              bad;
    logic [SET_W-1:0]  settle_cnt;
    logic [GOOD_W-1:0] good_cnt;
    logic [BAD_W-1:0]  bad_cnt;
    logic [TMO_W-1:0]  tmo_cnt;

    assign state = state_q;

    word_aligner #(
        .DW (DW),
        .SW (SW)
    ) u_word_aligner (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .slip         (slip),
        .flush        (flush),
        .aligned_data (aligned_data),
        .good         (good),
        .bad          (bad)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_PLL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Losing either PLL lock outside WAIT_PLL overrides
    // every other transition. The reference word is flushed whenever the
    // checker is idle, when LOCKED falls back to ALIGN, and after every bad
    // word in ALIGN so the new slip starts from a fresh reference.
    always_comb begin
        state_d  = state_q;
        pll_ok   = tx_pll_locked && rx_pll_locked;
        pll_loss = !pll_ok && (state_q != ST_WAIT_PLL);
        flush    = 1'b0;

        case (state_q)
            ST_WAIT_PLL: begin
                if (pll_ok) begin
                    state_d = ST_WAIT_SEQ;
                end
            end
            ST_WAIT_SEQ: begin
                if (tx_rst_seq_done && rx_rst_seq_done) begin
                    state_d = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (tx_rdy && rx_rdy) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_END) begin
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (good && (good_cnt == GOOD_END)) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (bad && (bad_cnt == BAD_END)) begin
                    state_d = ST_ALIGN;
                end
            end
            default: begin
                state_d = ST_WAIT_PLL;
            end
        endcase

        if (pll_loss) begin
            state_d = ST_WAIT_PLL;
        end

        flush = ((state_q != ST_ALIGN) && (state_q != ST_LOCKED))
             || ((state_q == ST_LOCKED) && (state_d == ST_ALIGN))
             || ((state_q == ST_ALIGN) && bad);
    end

    // Settle counter: counts cycles spent in SETTLE, zero everywhere else,
    // so the FSM leaves SETTLE after exactly SETTLE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if ((state_q == ST_SETTLE) && (state_d == ST_SETTLE)) begin
            settle_cnt <= settle_cnt + 1'b1;
        end else begin
            settle_cnt <= '0;
        end
    end

    // Consecutive good words while searching; any bad word restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt <= '0;
        end else if ((state_q == ST_ALIGN) && (state_d == ST_ALIGN)) begin
            if (bad) begin
                good_cnt <= '0;
            end else if (good) begin
                good_cnt <= good_cnt + 1'b1;
            end
        end else begin
            good_cnt <= '0;
        end
    end

    // Consecutive bad words while locked; any good word forgives them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_cnt <= '0;
        end else if ((state_q == ST_LOCKED) && (state_d == ST_LOCKED)) begin
            if (good) begin
                bad_cnt <= '0;
            end else if (bad) begin
                bad_cnt <= bad_cnt + 1'b1;
            end
        end else begin
            bad_cnt <= '0;
        end
    end

    // Rotation search: step to the next rotation on every bad word in ALIGN.
    // The value survives a LOCKED->ALIGN fallback but is forgotten on PLL loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slip <= '0;
        end else if (pll_loss) begin
            slip <= '0;
        end else if ((state_q == ST_ALIGN) && bad) begin
            slip <= (slip == SLIP_LAST) ? '0 : slip + 1'b1;
        end
    end

    // Link error counter: bad words seen while LOCKED, saturating, and kept
    // across PLL loss so the history survives a re-bring-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if ((state_q == ST_LOCKED) && bad && !pll_loss
                     && (err_cnt != ERR_CNT_MAX)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    // Alignment watchdog: counts cycles in ALIGN and cleared whenever ALIGN
    // is left. The flag is raised at the terminal count even if the same
    // cycle also declares lock, and only rst_n clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            if ((state_q == ST_ALIGN) && (state_d == ST_ALIGN)) begin
                if (tmo_cnt != TMO_MAX) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
            if ((state_q == ST_ALIGN) && !pll_loss && (tmo_cnt == TMO_END)) begin
                timeout <= 1'b1;
            end
        end
    end

    // Registered control outputs, derived from the state being entered so
    // they change on the same edge as 'state'.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            source_rst <= 1'b1;
            link_up    <= 1'b0;
            en_vtc     <= 1'b1;
        end else begin
            source_rst <= (state_d != ST_ALIGN) && (state_d != ST_LOCKED);
            link_up    <= (state_d == ST_LOCKED);
            en_vtc     <= 1'b1;
        end
    end

endmodule
